// File: rtl/pulse_width_meas_pkg.sv
// rtl/pulse_width_meas_pkg.sv - shared constants and state encoding for the pulse timing blocks
//
// Purpose: constants shared by the pulse-width meter and the pulse-stretching
//          delay block, plus the meter's state encoding.
// Ports:   none (package).
package pulse_width_meas_pkg;

   localparam int unsigned DEF_N = 28;

   // One second at 50 MHz, and a short stand-in used for simulation builds.
   localparam logic [27:0] T_1S  = 28'h2FA_F080;
   localparam logic [27:0] T_SIM = 28'h000_0008;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_MEAS = 2'd1,
      M_HOLD = 2'd2
   } meas_state_e;

endpackage

// File: rtl/pulse_width_meas_sync_edge.sv
// rtl/pulse_width_meas_sync_edge.sv - two-flop synchronizer with rising-edge detect
//
// Purpose: brings an asynchronous level into the clk domain and flags its
//          low-to-high transitions.
// Ports:   clk   - system clock
//          n_rst - asynchronous active-low reset
//          din   - asynchronous input level
//          din_s - synchronized level (two flops)
//          rise  - one-cycle flag: din_s went from 0 to 1
module sync_edge
   import pulse_width_meas_pkg::*;
(
   input  logic clk,
   input  logic n_rst,
   input  logic din,
   output logic din_s,
   output logic rise
);

   logic       sync1_q;
   logic       sync2_q;
   logic       hist_q;
   logic [1:0] warm_q;
   logic       armed_q;

   // The flops clear to 0, so a level that is already high at reset release
   // would look like a fresh edge.  Edges are only honoured once din_s has
   // been seen low after the synchronizer has refilled (warm_q).
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
         warm_q  <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
         warm_q  <= {warm_q[0], 1'b1};
         if (warm_q[1] && !sync2_q) begin
            armed_q <= 1'b1;
         end
      end
   end

   assign din_s = sync2_q;
   assign rise  = armed_q & sync2_q & ~hist_q;

endmodule

// File: rtl/pulse_width_meas.sv
// rtl/pulse_width_meas.sv - measures high-pulse width of an asynchronous input in clk cycles
//
// Purpose: times each high pulse on din; pulses shorter than T_MIN are
//          discarded, long pulses saturate and set ovf.  Results are offered
//          with a valid/ack handshake and held until acknowledged.
// Ports:   clk   - system clock
//          n_rst - asynchronous active-low reset
//          din   - asynchronous pulse input
//          ack   - consumer acknowledge, used only while valid=1
//          width - measured width in cycles, stable while valid=1
//          valid - measurement available
//          ovf   - width saturated during this pulse
//          busy  - a pulse is being measured
//          drop  - one-cycle strobe: a rising edge arrived while a result was pending
module pulse_width_meas
   import pulse_width_meas_pkg::*;
#(
   parameter int unsigned    N     = DEF_N,
   parameter logic [N-1:0]   T_MIN = N'(4)
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         din,
   input  logic         ack,
   output logic [N-1:0] width,
   output logic         valid,
   output logic         ovf,
   output logic         busy,
   output logic         drop
);

   localparam logic [N-1:0] ONE = N'(1);

   logic         din_s;
   logic         rise;

   meas_state_e  state_q;
   logic [N-1:0] count_q;
   logic [N-1:0] count_d;
   logic         ovf_r_q;
   logic [N-1:0] width_q;
   logic         valid_q;
   logic         ovf_q;
   logic         busy_q;
   logic         drop_q;

   sync_edge u_sync_edge (
      .clk   (clk),
      .n_rst (n_rst),
      .din   (din),
      .din_s (din_s),
      .rise  (rise)
   );

   // Saturating increment: an all-ones count holds rather than wrapping.
   assign count_d = (&count_q) ? count_q : count_q + ONE;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= M_IDLE;
         count_q <= '0;
         ovf_r_q <= 1'b0;
         width_q <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         case (state_q)
            M_IDLE: begin
               if (rise) begin
                  state_q <= M_MEAS;
                  count_q <= ONE;
                  ovf_r_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            M_MEAS: begin
               if (din_s) begin
                  count_q <= count_d;
                  if (&count_q) begin
                     ovf_r_q <= 1'b1;
                  end
               end else begin
                  busy_q <= 1'b0;
                  if (count_q >= T_MIN) begin
                     width_q <= count_q;
                     ovf_q   <= ovf_r_q;
                     valid_q <= 1'b1;
                     state_q <= M_HOLD;
                  end else begin
                     state_q <= M_IDLE;
                  end
               end
            end
            M_HOLD: begin
               // A pulse starting while the result is unconsumed is lost;
               // this holds even when ack arrives in the same cycle.
               if (rise) begin
                  drop_q <= 1'b1;
               end
               if (ack) begin
                  valid_q <= 1'b0;
                  state_q <= M_IDLE;
               end
            end
            default: begin
               state_q <= M_IDLE;
               count_q <= '0;
               ovf_r_q <= 1'b0;
               width_q <= '0;
               valid_q <= 1'b0;
               ovf_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign width = width_q;
   assign valid = valid_q;
   assign ovf   = ovf_q;
   assign busy  = busy_q;
   assign drop  = drop_q;

endmodule

// File: doc/pulse_width_meas.md
Name: pulse_width_meas

Overview:
Measures the width, in clk cycles, of each high pulse on an asynchronous input `din`. It is the receive-side counterpart of the pulse-stretching delay block, so it can check that block's 1 s output or time an external button or sensor.
- Each valid measurement is presented on `width` with a valid/ack handshake.
- Glitches shorter than T_MIN are rejected.
- Over-long pulses saturate and raise `ovf`.

Parameters:
N, 28, counter and `width` bit width
T_MIN, 28'd4, minimum accepted pulse width in cycles; shorter pulses are discarded silently (must be >= 1 and < 2^N)

Ports:
clk  input  1  system clock, 50 MHz (20 ns)
n_rst  input  1  reset, asynchronous, active-low
din  input  1  asynchronous pulse input to be measured
ack  input  1  consumer acknowledge; consumed only while valid=1
width  output  N  measured pulse width in cycles; held stable while valid=1
valid  output  1  measurement available
ovf  output  1  qualifies `width`: 1 if the counter saturated during this pulse
busy  output  1  1 while in M_MEAS
drop  output  1  single-cycle strobe: a rising edge was ignored because a result was pending

Behaviour:
- Reset (async, n_rst=0):
  - state=M_IDLE, count=0, width=0.
  - valid, ovf, busy, drop = 0; both sync flops and the edge-history flop = 0.
  - Reset mid-measurement or while valid is pending discards everything; there is no output after release until a fresh rising edge.
- Input conditioning:
  - 2-flop synchronizer gives din_s.
  - din_d is din_s delayed by one cycle.
  - rise = din_s & ~din_d.
- State machine (2-bit register, registered outputs):
  - M_IDLE:
    - On rise: go to M_MEAS, count <= 1, ovf_r <= 0.
    - Otherwise stay.
    - A level that is already high on entry to M_IDLE is not a rising edge; the block waits for a low-to-high transition.
  - M_MEAS, busy=1, din_s=1:
    - count <= count+1, saturating at all-ones.
    - If count is already all-ones, it holds and ovf_r <= 1.
  - M_MEAS, din_s=0 and count < T_MIN:
    - Glitch. Go to M_IDLE; no valid, width unchanged.
  - M_MEAS, din_s=0 and count >= T_MIN:
    - width <= count, ovf <= ovf_r, valid <= 1, go to M_HOLD.
  - M_HOLD:
    - valid=1; width and ovf are frozen.
    - On ack=1: valid <= 0 and go to M_IDLE at the next edge.
    - Any rise seen in M_HOLD, including the same cycle as ack, pulses drop=1 for one cycle and that pulse is not measured.
  - Unreachable encoding: go to M_IDLE, outputs cleared.
- Count semantics:
  - width = number of cycles din_s was sampled high.
  - For din high exactly W cycles, edge-aligned, width=W.
- Latency:
  - valid rises at the 3rd clk edge after the last edge at which din was sampled high (2 sync stages + 1 register).
  - Rising-edge-to-busy latency is 3 edges.
- Handshake:
  - ack while valid=0 is ignored.
  - ack held high continuously consumes each result one cycle after it appears.
  - valid never drops without ack, except on reset.
- Width rules:
  - Compare count >= T_MIN at N bits, unsigned.
  - Increment is N-bit; saturation detected by the all-ones test, never by wrap.

Decomposition:
- Shared package (also used by the delay block):
  - default N=28
  - T_1S=28'h2FA_F080 (5.0e7 cycles)
  - reduced simulation constant T_SIM=28'h000_0008
  - state localparams M_IDLE=2'd0, M_MEAS=2'd1, M_HOLD=2'd2
- One sub-module, sync_edge:
  - 2-flop synchronizer, history flop, `rise` output.
  - Ports: clk, n_rst, din, din_s, rise.
  - Reusable by the delay block's input.

Test Plan:
- Reset, then din high 5 cycles (T_MIN=4), ack tied 1 -> valid high 1 cycle, 3 edges after din's last high edge; width=5, ovf=0, busy high 5 cycles.
- din high 3 cycles (T_MIN=4) -> no valid, width stays 0, returns to M_IDLE; a following 6-cycle pulse -> width=6.
- Pulse of 10 cycles with ack=0, then a second pulse of 7 cycles -> width=10 held, valid stays 1, drop pulses once on the second pulse's rise edge; assert ack -> valid=0 next edge, width still 10.
- N=4 build, din high 20 cycles -> width=4'hF, ovf=1; next pulse of 5 cycles -> width=5, ovf=0.
- Loopback of the delay block (T=T_SIM=8) driven by a 1-cycle trigger -> width equals the delay block's high time, ovf=0.
- Assert n_rst low in M_MEAS after 4 cycles, release while din is still high -> no valid until din goes low and rises again; the new pulse is measured from its own rise.
